alu_operand_sequencer: RTL

ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

---
 rtl/alu_operand_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/alu_operand_sequencer.sv
// -----------------------------------------------------------------------------
// alu_operand_sequencer
//
// Purpose:
//   Holds a small operand register file. It takes single commands over a
//   valid/ready handshake, presents registered operands and a control code to
//   an external combinational ALU, writes the ALU result back, and returns the
//   result (or a plain register read) over a second valid/ready handshake.
//
//   Commands (in_op): 00 NOP, 01 LOAD R[rd] <= imm, 10 EXEC R[rd] <= ALU(R[rs1],
//   R[rs2]), 11 READ R[rs1]. The FSM accepts a command only in IDLE. EXEC
//   spends exactly one ISSUE cycle while the ALU evaluates.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        command handshake
//   in_op, in_ctrl             command code and ALU control code
//   in_rd, in_rs1, in_rs2      register indices
//   in_imm                     LOAD immediate
//   alu_a, alu_b, alu_ctrl     registered operands and control code to the ALU
//   alu_out, alu_carry,
//   alu_zero                   combinational ALU result and flags
//   res_valid / res_ready      response handshake
//   res_data, res_carry,
//   res_zero                   response payload
// -----------------------------------------------------------------------------
module alu_operand_sequencer #(
   parameter  int WIDTH = 6,
   parameter  int NREGS = 4,
   localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [3:0]       in_ctrl,
   input  logic [IDX_W-1:0] in_rd,
   input  logic [IDX_W-1:0] in_rs1,
   input  logic [IDX_W-1:0] in_rs2,
   input  logic [WIDTH-1:0] in_imm,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_carry,
   input  logic             alu_zero,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_carry,
   output logic             res_zero
);

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;
   localparam logic [1:0] OP_EXEC = 2'b10;
   localparam logic [1:0] OP_READ = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      RESP  = 2'b10
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] regs [NREGS];
   logic [IDX_W-1:0] rd_q;
   logic             accept;

   assign in_ready  = (state == IDLE);
   assign res_valid = (state == RESP);
   assign accept    = in_valid && in_ready;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: the next-state value gets a default before the case; every path
   // then assigns it, so no latch can be inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               if (in_op == OP_EXEC)      state_nxt = ISSUE;
               else if (in_op == OP_READ) state_nxt = RESP;
            end
         end
         ISSUE:   state_nxt = RESP;
         RESP:    if (res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------ datapath
   // NOTE: sequential state uses non-blocking assignments, so every read of
   // regs[] in this block sees the value from before the edge. That gives the
   // "sources read before destination write" behaviour for free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the register file is reset element by element on purpose.
         // A READ straight after reset must return 0, so it cannot be left as
         // an unreset RAM.
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_ctrl  <= '0;
         rd_q      <= '0;
         res_data  <= '0;
         res_carry <= 1'b0;
         res_zero  <= 1'b0;
      end else begin
         if (accept) begin
            case (in_op)
               OP_NOP:  ;
               OP_LOAD: regs[in_rd] <= in_imm;
               OP_EXEC: begin
                  alu_a    <= regs[in_rs1];
                  alu_b    <= regs[in_rs2];
                  alu_ctrl <= in_ctrl;
                  rd_q     <= in_rd;
               end
               OP_READ: begin
                  res_data  <= regs[in_rs1];
                  res_carry <= 1'b0;
                  res_zero  <= (regs[in_rs1] == '0);
               end
            endcase
         end
         // The ALU result is valid while alu_a/alu_b/alu_ctrl are presented
         // in ISSUE. Capture it unmodified.
         if (state == ISSUE) begin
            regs[rd_q] <= alu_out;
            res_data   <= alu_out;
            res_carry  <= alu_carry;
            res_zero   <= alu_zero;
         end
      end
   end

endmodule
